// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake into a one-entry holding register,
// start/8 data (LSB first)/optional parity/1-2 stop bits, CTS gating at frame
// boundaries so that frames can be sent back to back.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  input  logic       cts_n,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shifter;
  logic              par_bit;
  logic [7:0]        hold_data;
  logic              hold_full;
  logic              cts_meta;
  logic              cts_s;

  logic bit_end_c;
  logic last_stop_c;
  logic start_c;
  logic par_c;

  assign bit_end_c   = (baud_cnt == BAUD_LAST);
  assign last_stop_c = (state == STOP) && (bit_cnt == STOP_LAST);
  // A new frame may begin from idle or straight out of the final stop bit.
  assign start_c     = hold_full && !cts_s &&
                       ((state == IDLE) || (last_stop_c && bit_end_c));
  assign par_c       = (PARITY == 2) ? (^hold_data) : (~^hold_data);

  assign ready = ~hold_full;
  assign busy  = (state != IDLE) || hold_full;

  // Two-flop synchroniser for the asynchronous clear-to-send input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      cts_meta <= cts_n;
      cts_s    <= cts_meta;
    end
  end

  // Holding register, frame sequencer and registered line/done outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
      par_bit   <= 1'b0;
      hold_data <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      // High during the final clock of the last stop bit.
      tx_done <= last_stop_c && (baud_cnt == BAUD_PRE);

      if (valid && !hold_full) begin
        hold_data <= data_in;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
        end
        START: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shifter[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shifter <= {1'b0, shifter[7:1]};
              tx      <= shifter[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        PAR: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (last_stop_c) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase

      // Transfer from the holding register overrides the idle/stop exit.
      if (start_c) begin
        shifter   <= hold_data;
        par_bit   <= par_c;
        hold_full <= 1'b0;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        tx        <= 1'b0;
        state     <= START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLKS_PER_BIT = 4: a no-parity/1-stop instance checked
// through a byte scoreboard plus two parity instances checked bit by bit.
module tb_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       v0 = 1'b0;
  logic       v12 = 1'b0;
  logic       cts_n = 1'b0;

  logic ready0, tx0, busy0, tx_done0;
  logic ready1, tx1, busy1, tx_done1;
  logic ready2, tx2, busy2, tx_done2;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [7:0] exp_q[$];
  int done_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(data), .valid(v0), .ready(ready0),
    .cts_n(cts_n), .tx(tx0), .busy(busy0), .tx_done(tx_done0));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(data), .valid(v12), .ready(ready1),
    .cts_n(cts_n), .tx(tx1), .busy(busy1), .tx_done(tx_done1));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(data), .valid(v12), .ready(ready2),
    .cts_n(cts_n), .tx(tx2), .busy(busy2), .tx_done(tx_done2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of every tx_done pulse from the main instance.
  always @(negedge clk) begin
    if (tx_done0 === 1'b1) done_q.push_back(cyc);
  end

  // Scoreboard monitor: decode each frame of u0 and compare against the queue.
  always begin
    @(negedge clk);
    if (mon_en && tx0 === 1'b0) begin
      logic [7:0] exp_b;
      logic [7:0] got;
      logic [9:0] ebits;
      int bad;
      int dbad;
      bit aborted;
      exp_b = 8'h00;
      got = 8'h00;
      bad = 0;
      dbad = 0;
      aborted = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL frame_unexpected: frame started at cycle %0d with no byte queued", cyc);
      end else begin
        exp_b = exp_q.pop_front();
      end
      ebits = {1'b1, exp_b, 1'b0};
      for (int i = 0; i < 10 * int'(CPB); i++) begin
        if (i > 0) @(negedge clk);
        if (!mon_en) begin
          aborted = 1'b1;
          break;
        end
        if (tx0 !== ebits[i / int'(CPB)]) bad++;
        if ((i % int'(CPB)) == 2 && (i / int'(CPB)) >= 1 && (i / int'(CPB)) <= 8)
          got[(i / int'(CPB)) - 1] = tx0;
        if (tx_done0 !== (i == 10 * int'(CPB) - 1)) dbad++;
      end
      if (!aborted) begin
        checks++;
        if (got !== exp_b)
          $display("FAIL frame_data: got %02h expected %02h", got, exp_b);
        else passes++;
        checks++;
        if (bad !== 0)
          $display("FAIL frame_bits: %0d cycles wrong on tx for byte %02h, expected 0", bad, exp_b);
        else passes++;
        checks++;
        if (dbad !== 0)
          $display("FAIL frame_done: %0d cycles of wrong tx_done for byte %02h, expected 0", dbad, exp_b);
        else passes++;
      end
    end
  end

  task automatic send0(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    data = b;
    v0 = 1'b1;
    while (ready0 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ready0 !== 1'b1) begin
      checks++;
      $display("FAIL send_timeout: ready got %b expected 1 for byte %02h", ready0, b);
    end
    @(posedge clk);
    exp_q.push_back(b);
    #1;
    acc = cyc;
    v0 = 1'b0;
    data = 8'hxx;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((busy0 || busy1 || busy2) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (busy0 || busy1 || busy2) begin
      checks++;
      $display("FAIL wait_idle: busy got %b%b%b after %0d cycles expected 000", busy0, busy1, busy2, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (tx0 !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx0); else passes++;
    checks++; if (ready0 !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready0); else passes++;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy0); else passes++;
    checks++; if (tx_done0 !== 1'b0) $display("FAIL reset_done: got %b expected 0", tx_done0); else passes++;
    checks++; if ({tx1, tx2} !== 2'b11) $display("FAIL reset_tx_par: got %b expected 11", {tx1, tx2}); else passes++;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic;
    int acc;
    done_q.delete();
    send0(8'h55, acc);
    @(negedge clk);
    checks++; if (tx0 !== 1'b1) $display("FAIL basic_tx_hold: got %b expected 1", tx0); else passes++;
    checks++; if (ready0 !== 1'b0) $display("FAIL basic_ready_low: got %b expected 0", ready0); else passes++;
    @(negedge clk);
    checks++; if (tx0 !== 1'b0) $display("FAIL basic_tx_fall: got %b expected 0", tx0); else passes++;
    checks++; if (ready0 !== 1'b1) $display("FAIL basic_ready_back: got %b expected 1", ready0); else passes++;
    wait_idle(200);
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== acc + 40)
      $display("FAIL basic_done_time: got %0d pulses first at +%0d expected 1 at +40",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - acc : -1);
    else passes++;
  endtask

  task automatic test_parity;
    logic [11:0] ev;
    logic [11:0] od;
    int bad1, bad2, dbad1, dbad2;
    ev = 12'b1110_0000_1110;
    od = 12'b1100_0000_1110;
    bad1 = 0; bad2 = 0; dbad1 = 0; dbad2 = 0;
    @(negedge clk);
    data = 8'h07;
    v12 = 1'b1;
    checks++;
    if ({ready1, ready2} !== 2'b11) $display("FAIL par_ready: got %b expected 11", {ready1, ready2}); else passes++;
    @(posedge clk);
    #1;
    v12 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12 * int'(CPB); i++) begin
      @(negedge clk);
      if (tx2 !== ev[i / int'(CPB)]) bad2++;
      if (tx1 !== od[i / int'(CPB)]) bad1++;
      if (tx_done2 !== (i == 12 * int'(CPB) - 1)) dbad2++;
      if (tx_done1 !== (i == 12 * int'(CPB) - 1)) dbad1++;
    end
    checks++; if (bad2 !== 0) $display("FAIL even_bits: %0d wrong cycles expected 0", bad2); else passes++;
    checks++; if (bad1 !== 0) $display("FAIL odd_bits: %0d wrong cycles expected 0", bad1); else passes++;
    checks++; if (dbad2 !== 0) $display("FAIL even_done: %0d wrong cycles expected 0", dbad2); else passes++;
    checks++; if (dbad1 !== 0) $display("FAIL odd_done: %0d wrong cycles expected 0", dbad1); else passes++;
    @(negedge clk);
    checks++;
    if ({busy1, busy2} !== 2'b00) $display("FAIL par_idle_after_48: got %b expected 00", {busy1, busy2}); else passes++;
    wait_idle(200);
  endtask

  task automatic test_back_to_back;
    int acc1, acc2, rbad;
    rbad = 0;
    done_q.delete();
    send0(8'hA5, acc1);
    while (cyc < acc1 + 8) @(negedge clk);
    send0(8'h3C, acc2);
    while (cyc < acc1 + 41) begin
      @(negedge clk);
      if (cyc <= acc1 + 40 && ready0 !== 1'b0) rbad++;
    end
    checks++; if (rbad !== 0) $display("FAIL b2b_ready_low: %0d cycles ready high expected 0", rbad); else passes++;
    checks++; if (tx0 !== 1'b0) $display("FAIL b2b_no_gap_tx: got %b expected 0", tx0); else passes++;
    checks++; if (ready0 !== 1'b1) $display("FAIL b2b_ready_back: got %b expected 1", ready0); else passes++;
    wait_idle(300);
    checks++;
    if (done_q.size() !== 2 || done_q[0] !== acc1 + 40 || done_q[1] !== acc1 + 80)
      $display("FAIL b2b_done_times: got %0d pulses first at +%0d expected 2 at +40 and +80",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - acc1 : -1);
    else passes++;
  endtask

  task automatic test_flow;
    int acc, txbad, bbad, rbad;
    txbad = 0; bbad = 0; rbad = 0;
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    send0(8'h41, acc);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) txbad++;
      if (busy0 !== 1'b1) bbad++;
      if (ready0 !== 1'b0) rbad++;
    end
    checks++; if (txbad !== 0) $display("FAIL flow_tx_held: %0d cycles tx low expected 0", txbad); else passes++;
    checks++; if (bbad !== 0) $display("FAIL flow_busy: %0d cycles busy low expected 0", bbad); else passes++;
    checks++; if (rbad !== 0) $display("FAIL flow_ready: %0d cycles ready high expected 0", rbad); else passes++;
    cts_n = 1'b0;
    @(negedge clk);
    checks++; if (tx0 !== 1'b1) $display("FAIL flow_edge1: got %b expected 1", tx0); else passes++;
    @(negedge clk);
    checks++; if (tx0 !== 1'b1) $display("FAIL flow_edge2: got %b expected 1", tx0); else passes++;
    @(negedge clk);
    checks++; if (tx0 !== 1'b0) $display("FAIL flow_edge3: got %b expected 0", tx0); else passes++;
    wait_idle(200);
  endtask

  task automatic test_cts_mid;
    int acc1, acc2, hbad;
    hbad = 0;
    done_q.delete();
    send0(8'h12, acc1);
    while (cyc < acc1 + 8) @(negedge clk);
    send0(8'h34, acc2);
    @(negedge clk);
    cts_n = 1'b1;
    while (cyc < acc1 + 41) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (tx0 !== 1'b1 || busy0 !== 1'b1 || ready0 !== 1'b0) hbad++;
      @(negedge clk);
    end
    checks++; if (hbad !== 0) $display("FAIL cts_mid_hold: %0d bad cycles expected 0", hbad); else passes++;
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== acc1 + 40)
      $display("FAIL cts_mid_first_done: got %0d pulses expected 1 at +40", done_q.size());
    else passes++;
    cts_n = 1'b0;
    wait_idle(200);
    checks++; if (done_q.size() !== 2) $display("FAIL cts_mid_second: got %0d pulses expected 2", done_q.size()); else passes++;
  endtask

  task automatic test_reset_mid;
    int acc1, acc2, rbad;
    rbad = 0;
    send0(8'hF0, acc1);
    while (cyc < acc1 + 8) @(negedge clk);
    send0(8'h99, acc2);
    while (cyc < acc1 + 18) @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (tx0 !== 1'b1) $display("FAIL rstmid_tx: got %b expected 1", tx0); else passes++;
    checks++; if (ready0 !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", ready0); else passes++;
    checks++; if (busy0 !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy0); else passes++;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) rbad++;
    end
    checks++; if (rbad !== 0) $display("FAIL rstmid_residual: %0d active cycles expected 0", rbad); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_flow();
    test_cts_mid();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d bytes left expected 0", exp_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
